// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture engine: register map, bit positions,
// capture state encoding and DATA word layout.
package adc_capture_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_DECIM  = 3'd1;
  localparam logic [2:0] ADDR_THRESH = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_DATA   = 3'd4;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_ARM    = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_FILL_W    = 16;
  localparam int STAT_EMPTY     = 16;
  localparam int STAT_FULL      = 17;
  localparam int STAT_OVERFLOW  = 18;
  localparam int STAT_TRIGGERED = 19;
  localparam int STAT_STATE_LSB = 20;

  localparam int DATA_VALID_BIT = 31;
  localparam int DATA_CH_LSB    = 16;
  localparam int DATA_SAMPLE_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/adc_capture_fifo.sv
// Synchronous FIFO holding channel-tagged samples; clear has priority over
// push and pop, a push into a full FIFO or a pop from an empty one is ignored.
module adc_capture_fifo #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 22,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full & ~clr;
  assign pop_ok  = pop & ~empty & ~clr;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/adc_capture_mm.sv
// Multi-channel ADC capture engine with decimation, channel-tagged FIFO and
// Avalon-MM register access. Define ADC_CAPTURE_TRIGGER_EN for threshold-triggered capture.
module adc_capture_mm
  import adc_capture_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 14,
  parameter int DEPTH    = 256,
  parameter int DECIM_W  = 16
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic [CHANNELS*DATA_W-1:0] adc_data_i,
  input  logic                       adc_valid_i,
  input  logic [2:0]                 avs_address,
  input  logic                       avs_read,
  input  logic                       avs_write,
  input  logic [31:0]                avs_writedata,
  output logic [31:0]                avs_readdata,
  output logic                       irq
);

  localparam int FW = CHANNELS * DATA_W;
  localparam int EW = 8 + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ROOM_MAX = CW'(DEPTH - CHANNELS);
  localparam logic [CW-1:0] HALF     = CW'(DEPTH / 2);
  localparam logic [7:0]    LAST_CH  = 8'(CHANNELS - 1);

  logic               enable_reg;
  logic               irq_en_reg;
  logic               overflow_reg;
  logic               busy_reg;
  logic [DECIM_W-1:0] decim_reg;
  logic [DECIM_W-1:0] cnt_reg;
  logic [FW-1:0]      frame_reg;
  logic [7:0]         ch_reg;
  logic [31:0]        readdata_reg;
  cap_state_t         state_reg;
  cap_state_t         state_next;

  logic               wr_ctrl;
  logic               clear;
  logic               arm;
  logic               strobe_ok;
  logic               room;
  logic               fits;
  logic               thresh_hit;
  logic               trig_event;
  logic               capture_open;
  logic               done_flag;
  logic               frame_take;
  logic               admit;
  logic               drop;
  logic               triggered;
  logic [31:0]        thresh_word;
  logic [31:0]        read_value;

  logic               fifo_pop;
  logic [EW-1:0]      fifo_push_data;
  logic [EW-1:0]      fifo_pop_data;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               unused_bits;

  assign unused_bits = ^avs_writedata;

  assign wr_ctrl   = avs_write & (avs_address == ADDR_CTRL);
  assign clear     = wr_ctrl & avs_writedata[CTRL_CLEAR];
  assign strobe_ok = adc_valid_i & enable_reg & (cnt_reg == '0);
  assign room      = (fifo_count <= ROOM_MAX);
  // A frame is admitted only whole: the serialiser must be free and the FIFO
  // must already have space for every channel of it.
  assign fits      = ~busy_reg & room;

`ifdef ADC_CAPTURE_TRIGGER_EN
  logic [DATA_W-1:0] thresh_reg;
  logic              triggered_reg;

  assign arm         = wr_ctrl & avs_writedata[CTRL_ARM] & enable_reg;
  assign thresh_hit  = (adc_data_i[DATA_W-1:0] >= thresh_reg);
  assign triggered   = triggered_reg;
  assign thresh_word = 32'(thresh_reg);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      thresh_reg    <= '0;
      triggered_reg <= 1'b0;
    end else begin
      if (avs_write && (avs_address == ADDR_THRESH)) begin
        thresh_reg <= avs_writedata[DATA_W-1:0];
      end
      if (clear || arm) begin
        triggered_reg <= 1'b0;
      end else if (trig_event) begin
        triggered_reg <= 1'b1;
      end
    end
  end
`else
  assign arm         = 1'b0;
  assign thresh_hit  = 1'b0;
  assign triggered   = 1'b0;
  assign thresh_word = '0;
`endif

  assign trig_event = strobe_ok & (state_reg == ST_ARMED) & thresh_hit & ~clear;

  // FSM: state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
`ifdef ADC_CAPTURE_TRIGGER_EN
      ST_IDLE: begin
        if (arm) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enable_reg) state_next = ST_IDLE;
        else if (trig_event) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!enable_reg && !busy_reg) state_next = ST_IDLE;
        else if (!room) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (clear) state_next = ST_IDLE;
        else if (arm) state_next = ST_ARMED;
      end
`else
      ST_IDLE: begin
        if (enable_reg) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!enable_reg && !busy_reg) state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    capture_open = 1'b0;
    done_flag    = 1'b0;
    case (state_reg)
      ST_CAPTURE: capture_open = 1'b1;
      ST_ARMED:   capture_open = thresh_hit;
      ST_DONE:    done_flag    = 1'b1;
      default:    capture_open = 1'b0;
    endcase
  end

  assign frame_take = strobe_ok & capture_open & ~clear;
  assign admit      = frame_take & fits;
  assign drop       = frame_take & ~fits;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      enable_reg   <= 1'b0;
      irq_en_reg   <= 1'b0;
      decim_reg    <= '0;
      cnt_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable_reg <= avs_writedata[CTRL_ENABLE];
        irq_en_reg <= avs_writedata[CTRL_IRQ_EN];
      end
      if (avs_write && (avs_address == ADDR_DECIM)) begin
        decim_reg <= avs_writedata[DECIM_W-1:0];
      end
      if (wr_ctrl && avs_writedata[CTRL_ENABLE] && !enable_reg) begin
        cnt_reg <= decim_reg;
      end else if (adc_valid_i && enable_reg) begin
        cnt_reg <= (cnt_reg == '0) ? decim_reg : cnt_reg - DECIM_W'(1);
      end
      // A lost frame is never hidden by a simultaneous acknowledge.
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clear ||
                   (avs_write && (avs_address == ADDR_STATUS) && avs_writedata[STAT_OVERFLOW])) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Serialiser: latch the frame, then emit one channel per cycle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      frame_reg <= '0;
      busy_reg  <= 1'b0;
      ch_reg    <= '0;
    end else if (clear) begin
      busy_reg <= 1'b0;
      ch_reg   <= '0;
    end else if (admit) begin
      frame_reg <= adc_data_i;
      busy_reg  <= 1'b1;
      ch_reg    <= '0;
    end else if (busy_reg) begin
      frame_reg <= frame_reg >> DATA_W;
      ch_reg    <= ch_reg + 8'd1;
      if (ch_reg == LAST_CH) begin
        busy_reg <= 1'b0;
      end
    end
  end

  assign fifo_push_data = {ch_reg, frame_reg[DATA_W-1:0]};
  assign fifo_pop       = avs_read & (avs_address == ADDR_DATA);

  adc_capture_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .clr       (clear),
    .push      (busy_reg),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    read_value = '0;
    case (avs_address)
      ADDR_CTRL: begin
        read_value[CTRL_ENABLE] = enable_reg;
        read_value[CTRL_IRQ_EN] = irq_en_reg;
      end
      ADDR_DECIM:  read_value = 32'(decim_reg);
      ADDR_THRESH: read_value = thresh_word;
      ADDR_STATUS: begin
        read_value[STAT_FILL_W-1:0]               = STAT_FILL_W'(fifo_count);
        read_value[STAT_EMPTY]                    = fifo_empty;
        read_value[STAT_FULL]                     = fifo_full;
        read_value[STAT_OVERFLOW]                 = overflow_reg;
        read_value[STAT_TRIGGERED]                = triggered;
        read_value[STAT_STATE_LSB +: 2]           = state_reg;
      end
      ADDR_DATA: begin
        if (!fifo_empty) begin
          read_value[DATA_VALID_BIT]              = 1'b1;
          read_value[DATA_CH_LSB +: 8]            = fifo_pop_data[EW-1 -: 8];
          read_value[DATA_SAMPLE_W-1:0]           = DATA_SAMPLE_W'(fifo_pop_data[DATA_W-1:0]);
        end
      end
      default: read_value = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      readdata_reg <= '0;
    end else if (avs_read) begin
      readdata_reg <= read_value;
    end
  end

  assign avs_readdata = readdata_reg;
  assign irq = irq_en_reg & ((fifo_count >= HALF) | overflow_reg | done_flag);

endmodule
